// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter of ALU (A) and load (B) writebacks onto the regfile write port, with pending-register scoreboard
// Ports: clk, rst_n (async, active low); hold_wb blocks grants;
//   rsv_valid/rsv_addr reserve a destination;
//   a_*/b_* are valid/ready write sources;
//   RegWrite/WriteRegister/WriteData drive the regfile write port one cycle after a grant;
//   pending[r] = reg r awaits writeback.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_wb,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [2**ADDR_W-1:0] pending
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [NREG-1:0] lsb = NREG'(1);
  logic last_b;
  logic gnt_a, gnt_b, g_write;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [NREG-1:0] clr, set, pend_next;
  always_comb begin
    gnt_a = !hold_wb && a_valid && (!b_valid || last_b);
    gnt_b = !hold_wb && b_valid && (!a_valid || !last_b);
    g_addr = gnt_a ? a_addr : b_addr;
    g_data = gnt_a ? a_data : b_data;
    g_write = (gnt_a || gnt_b) && g_addr != '0;
    clr = g_write ? lsb << g_addr : '0;
    set = rsv_valid ? lsb << rsv_addr : '0;
    // set applied after clear so a same-cycle reservation survives; bit 0 never pends
    pend_next = ((pending & ~clr) | set) & ~lsb;
  end
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
      RegWrite <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
      pending <= '0;
    end else begin
      RegWrite <= g_write;
      pending <= pend_next;
      if (gnt_a || gnt_b) last_b <= gnt_b;
      if (g_write) begin
        WriteRegister <= g_addr;
        WriteData <= g_data;
      end
    end
  end
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    a_valid && !a_ready |=> a_valid && $stable(a_addr) && $stable(a_data));
  b_hold: assert property (@(posedge clk) disable iff (!rst_n)
    b_valid && !b_ready |=> b_valid && $stable(b_addr) && $stable(b_data));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench with a rule-level model for the writeback arbiter
module tb_regfile_wb_arbiter;
  typedef struct {logic [4:0] addr; logic [31:0] data;} wr_t;
  logic clk = 0, rst_n = 0, hold_wb = 0, rsv_valid = 0;
  logic [4:0] rsv_addr = '0, a_addr = '0, b_addr = '0, WriteRegister;
  logic a_valid = 0, b_valid = 0, a_ready, b_ready, RegWrite;
  logic [31:0] a_data = '0, b_data = '0, WriteData, pending;
  int checks = 0, failures = 0;
  wr_t qa[$], qb[$];
  int m_last, m_w, c_w;
  logic m_rw;
  logic [4:0] m_wr, m_ga;
  logic [31:0] m_wd, m_pend;
  logic [4:0] rr_reg [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
  logic [31:0] rr_dat [6] = '{32'hA1, 32'hB2, 32'hA3, 32'hB4, 32'hA5, 32'hB6};

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hold_wb(hold_wb), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // 0 = nobody, 1 = A, 2 = B; with both asking, whoever was not served last wins
  function automatic int winner();
    if (hold_wb) return 0;
    if (a_valid && b_valid) return m_last == 1 ? 2 : 1;
    return a_valid ? 1 : b_valid ? 2 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 2; m_rw = 0; m_wr = '0; m_wd = '0; m_pend = '0;
    end else begin
      m_w = winner();
      m_ga = m_w == 1 ? a_addr : b_addr;
      m_rw = m_w != 0 && m_ga != 0;
      if (m_rw) begin
        m_wr = m_ga;
        m_wd = m_w == 1 ? a_data : b_data;
        m_pend[m_ga] = 1'b0;
      end
      if (m_w != 0) m_last = m_w;
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    c_w = winner();
    check("a_ready", a_ready, c_w == 1);
    check("b_ready", b_ready, c_w == 2);
    check("RegWrite", RegWrite, m_rw);
    check("WriteRegister", WriteRegister, m_wr);
    check("WriteData", WriteData, m_wd);
    check("pending", pending, m_pend);
  end

  task automatic load();
    a_valid = qa.size() > 0;
    if (a_valid) begin a_addr = qa[0].addr; a_data = qa[0].data; end
    b_valid = qb.size() > 0;
    if (b_valid) begin b_addr = qb[0].addr; b_data = qb[0].data; end
  endtask

  task automatic tick();
    logic ta, tb;
    @(negedge clk);
    ta = a_valid && a_ready;
    tb = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (ta) void'(qa.pop_front());
    if (tb) void'(qb.pop_front());
    load();
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rsv_valid = 1; rsv_addr = 5'd3;
    qa.push_back('{5'd9, 32'h99});
    qa.push_back('{5'd12, 32'h1212});
    load();
    #1 check("first_a_ready", a_ready, 1);
    tick();
    rsv_valid = 0;
    check("pre_rst_regwrite", RegWrite, 1);
    check("pre_rst_wreg", WriteRegister, 9);
    check("pre_rst_pend3", pending[3], 1);
    rst_n = 0;
    #1;
    check("rst_regwrite", RegWrite, 0);
    check("rst_pending", pending, 0);
    check("rst_wreg", WriteRegister, 0);
    qa.delete();
    load();
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < 6; i += 2) begin
      qa.push_back('{rr_reg[i], rr_dat[i]});
      qb.push_back('{rr_reg[i+1], rr_dat[i+1]});
    end
    load();
    #1;
    check("rr_first_a", a_ready, 1);
    check("rr_first_b", b_ready, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_regwrite", RegWrite, 1);
      check("rr_wreg", WriteRegister, rr_reg[i]);
      check("rr_wdata", WriteData, rr_dat[i]);
    end
    tick();
    check("idle_regwrite", RegWrite, 0);
    check("idle_hold_wreg", WriteRegister, 6);
    rsv_valid = 1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 0;
    check("rsv7_set", pending[7], 1);
    tick();
    qb.push_back('{5'd7, 32'h77});
    load();
    #1 check("b7_ready", b_ready, 1);
    tick();
    check("rsv7_clear", pending[7], 0);
    check("b7_wreg", WriteRegister, 7);
    rsv_valid = 1; rsv_addr = 5'd7;
    qa.push_back('{5'd7, 32'h7A});
    load();
    #1 check("a7_ready", a_ready, 1);
    tick();
    rsv_valid = 0;
    check("set_wins", pending[7], 1);
    check("a7_wdata", WriteData, 32'h7A);
    rsv_valid = 1; rsv_addr = 5'd0;
    qa.push_back('{5'd0, 32'h0BAD});
    load();
    #1 check("zero_ready", a_ready, 1);
    tick();
    rsv_valid = 0;
    check("zero_regwrite", RegWrite, 0);
    check("zero_wreg_held", WriteRegister, 7);
    check("zero_wdata_held", WriteData, 32'h7A);
    check("zero_pend0", pending[0], 0);
    hold_wb = 1;
    qa.push_back('{5'd10, 32'hA10});
    qb.push_back('{5'd11, 32'hB11});
    load();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_a", a_ready, 0);
      check("hold_b", b_ready, 0);
      tick();
      check("hold_regwrite", RegWrite, 0);
    end
    hold_wb = 0;
    #1;
    check("resume_b", b_ready, 1);
    check("resume_a", a_ready, 0);
    tick();
    check("resume_wreg_b", WriteRegister, 11);
    check("resume_a2", a_ready, 1);
    tick();
    check("resume_wreg_a", WriteRegister, 10);
    check("resume_wdata_a", WriteData, 32'hA10);
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) tick();
    check("queues_drained", qa.size() + qb.size(), 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
